// File: rtl/morse_rx_decoder.sv
// Morse receiver: times marks/spaces on an active-low key line, classifies dots/dashes,
// and emits S / O / unknown characters plus an S-O-S sequence flag.
module morse_rx_decoder #(
    parameter logic [15:0] T1MS        = 16'd49_999,
    parameter logic [9:0]  GLITCH_MS   = 10'd10,
    parameter logic [9:0]  DASH_MS     = 10'd250,
    parameter logic [9:0]  CHAR_GAP_MS = 10'd300
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       start_sig,
    input  logic       pin_in,
    output logic       done_sig,
    output logic [1:0] char_code,
    output logic [3:0] sym_bits,
    output logic [2:0] sym_cnt,
    output logic       sos_sig
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MARK = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_EMIT = 2'd3;

    localparam logic [1:0] CH_S = 2'b01;
    localparam logic [1:0] CH_O = 2'b10;
    localparam logic [1:0] CH_X = 2'b11;

    localparam logic [9:0] DUR_MAX = 10'h3FF;

    // Synchronizer and edge flags; the idle line level is high, so reset to 1.
    logic [1:0] sync_q;
    logic       pin_s;
    logic       pin_prev_q;
    logic       fall_q, rise_q;
    logic       edge_any;

    assign pin_s    = sync_q[1];
    assign edge_any = fall_q | rise_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_q     <= 2'b11;
            pin_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], pin_in};
            pin_prev_q <= pin_s;
            fall_q     <= pin_prev_q & ~pin_s;
            rise_q     <= ~pin_prev_q & pin_s;
        end
    end

    // Millisecond timebase. Cleared on the registered edge flag so the FSM still
    // sees the finished duration in the same cycle it reacts to that edge.
    logic [1:0]  state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [9:0]  dur_q, dur_d;
    logic        tick;

    assign tick = (presc_q == T1MS);

    always_comb begin
        presc_d = presc_q + 16'd1;
        if (tick || edge_any || state_q == ST_IDLE)
            presc_d = 16'd0;
    end

    always_comb begin
        dur_d = dur_q;
        if (edge_any)
            dur_d = 10'd0;
        else if (tick && dur_q != DUR_MAX)
            dur_d = dur_q + 10'd1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            presc_q <= 16'd0;
            dur_q   <= 10'd0;
        end else begin
            presc_q <= presc_d;
            dur_q   <= dur_d;
        end
    end

    // Symbol accumulator, history and FSM
    logic [3:0] acc_bits_q, acc_bits_d;
    logic [2:0] acc_cnt_q, acc_cnt_d;
    logic       ovf_q, ovf_d;
    logic       pend_q, pend_d;
    logic [1:0] hist1_q, hist1_d;
    logic [1:0] hist2_q, hist2_d;
    logic       emit_go;
    logic [1:0] cur_code;

    always_comb begin
        cur_code = CH_X;
        if (!ovf_q && acc_cnt_q == 3'd3 && acc_bits_q == 4'b0000)
            cur_code = CH_S;
        else if (!ovf_q && acc_cnt_q == 3'd3 && acc_bits_q == 4'b0111)
            cur_code = CH_O;
    end

    always_comb begin
        state_d    = state_q;
        acc_bits_d = acc_bits_q;
        acc_cnt_d  = acc_cnt_q;
        ovf_d      = ovf_q;
        pend_d     = pend_q;
        hist1_d    = hist1_q;
        hist2_d    = hist2_q;
        emit_go    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // pend_q covers a mark that began in the cycle the gap expired.
                if (fall_q || (pend_q && !pin_s))
                    state_d = ST_MARK;
                pend_d = 1'b0;
            end
            ST_MARK: begin
                if (rise_q) begin
                    if (dur_q < GLITCH_MS) begin
                        state_d = (acc_cnt_q != 3'd0) ? ST_GAP : ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        if (acc_cnt_q == 3'd4) begin
                            ovf_d = 1'b1;
                        end else begin
                            acc_bits_d[acc_cnt_q[1:0]] = (dur_q >= DASH_MS);
                            acc_cnt_d = acc_cnt_q + 3'd1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (dur_q >= CHAR_GAP_MS) begin
                    state_d = ST_EMIT;
                    emit_go = 1'b1;
                    pend_d  = fall_q;
                    hist2_d = hist1_q;
                    hist1_d = cur_code;
                end else if (fall_q) begin
                    state_d = ST_MARK;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                acc_bits_d = 4'b0000;
                acc_cnt_d  = 3'd0;
                ovf_d      = 1'b0;
            end
        endcase

        if (!start_sig) begin
            state_d    = ST_IDLE;
            acc_bits_d = 4'b0000;
            acc_cnt_d  = 3'd0;
            ovf_d      = 1'b0;
            pend_d     = 1'b0;
            hist1_d    = 2'b00;
            hist2_d    = 2'b00;
            emit_go    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            acc_bits_q <= 4'b0000;
            acc_cnt_q  <= 3'd0;
            ovf_q      <= 1'b0;
            pend_q     <= 1'b0;
            hist1_q    <= 2'b00;
            hist2_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            acc_bits_q <= acc_bits_d;
            acc_cnt_q  <= acc_cnt_d;
            ovf_q      <= ovf_d;
            pend_q     <= pend_d;
            hist1_q    <= hist1_d;
            hist2_q    <= hist2_d;
        end
    end

    // Outputs are loaded on the way into EMIT, so done_sig is high during EMIT.
    logic       done_q, done_d;
    logic       sos_q, sos_d;
    logic [1:0] code_q, code_d;
    logic [3:0] bits_q, bits_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        done_d = emit_go;
        sos_d  = emit_go && hist2_q == CH_S && hist1_q == CH_O && cur_code == CH_S;
        code_d = code_q;
        bits_d = bits_q;
        cnt_d  = cnt_q;
        if (emit_go) begin
            code_d = cur_code;
            bits_d = acc_bits_q;
            cnt_d  = acc_cnt_q;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            done_q <= 1'b0;
            sos_q  <= 1'b0;
            code_q <= 2'b00;
            bits_q <= 4'b0000;
            cnt_q  <= 3'd0;
        end else begin
            done_q <= done_d;
            sos_q  <= sos_d;
            code_q <= code_d;
            bits_q <= bits_d;
            cnt_q  <= cnt_d;
        end
    end

    assign done_sig  = done_q;
    assign sos_sig   = sos_q;
    assign char_code = code_q;
    assign sym_bits  = bits_q;
    assign sym_cnt   = cnt_q;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder: 4 clocks per ms, default thresholds.
module tb_morse_rx_decoder;

    localparam int CPM = 4;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       start_sig = 1'b0;
    logic       pin_in = 1'b1;
    logic       done_sig;
    logic [1:0] char_code;
    logic [3:0] sym_bits;
    logic [2:0] sym_cnt;
    logic       sos_sig;

    morse_rx_decoder #(.T1MS(16'd3)) dut (
        .CLK(CLK), .RSTn(RSTn), .start_sig(start_sig), .pin_in(pin_in),
        .done_sig(done_sig), .char_code(char_code), .sym_bits(sym_bits),
        .sym_cnt(sym_cnt), .sos_sig(sos_sig)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    int         done_cnt = 0;
    int         sos_cnt = 0;
    int         bad_pulse = 0;
    logic       done_prev = 1'b0;
    logic [1:0] cap_code = 2'b00;
    logic [3:0] cap_bits = 4'b0000;
    logic [2:0] cap_cnt = 3'd0;
    logic       cap_sos = 1'b0;

    always @(negedge CLK) begin
        if (done_sig) begin
            done_cnt <= done_cnt + 1;
            cap_code <= char_code;
            cap_bits <= sym_bits;
            cap_cnt  <= sym_cnt;
            cap_sos  <= sos_sig;
        end
        if (sos_sig) sos_cnt <= sos_cnt + 1;
        if ((sos_sig && !done_sig) || (done_sig && done_prev)) bad_pulse <= bad_pulse + 1;
        done_prev <= done_sig;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic mark(input int ms);
        pin_in = 1'b0;
        cyc(ms * CPM + 2);
        pin_in = 1'b1;
    endtask

    task automatic space(input int ms);
        cyc(ms * CPM);
    endtask

    task automatic send(input int n, input int d [5]);
        for (int i = 0; i < n; i++) begin
            if (i > 0) space(50);
            mark(d[i]);
        end
    endtask

    task automatic expect_char(input string tag, input logic [1:0] code, input logic [3:0] bits,
                               input logic [2:0] cnt, input logic sos);
        space(310);
        exp_done++;
        chk($sformatf("%s_done", tag), done_cnt, exp_done);
        chk($sformatf("%s_code", tag), cap_code, code);
        chk($sformatf("%s_bits", tag), cap_bits, bits);
        chk($sformatf("%s_cnt", tag), cap_cnt, cnt);
        chk($sformatf("%s_sos", tag), cap_sos, sos);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk($sformatf("%s_done", tag), done_sig, 0);
        chk($sformatf("%s_sos", tag), sos_sig, 0);
        chk($sformatf("%s_code", tag), char_code, 0);
        chk($sformatf("%s_bits", tag), sym_bits, 0);
        chk($sformatf("%s_cnt", tag), sym_cnt, 0);
    endtask

    initial begin
        // Reset with the line toggling
        start_sig = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pin_in = ~pin_in;
            cyc(3);
        end
        pin_in = 1'b1;
        chk_reset_outs("rst");
        RSTn = 1'b1;
        cyc(50);
        chk("rst_nodone", done_cnt, 0);

        // S, with emit timing bracketed around the 300 ms gap
        send(3, '{100, 100, 100, 0, 0});
        space(290);
        chk("s_early", done_cnt, 0);
        cyc(20 * CPM);
        exp_done++;
        chk("s_done", done_cnt, exp_done);
        chk("s_code", cap_code, 2'b01);
        chk("s_bits", cap_bits, 4'b0000);
        chk("s_cnt", cap_cnt, 3'd3);
        chk("s_sos", cap_sos, 1'b0);

        // O then S completes S-O-S
        send(3, '{400, 400, 400, 0, 0});
        expect_char("o", 2'b10, 4'b0111, 3'd3, 1'b0);
        send(3, '{100, 100, 100, 0, 0});
        expect_char("sos", 2'b01, 4'b0000, 3'd3, 1'b1);

        // Lone glitch produces nothing; a glitch inside a character is dropped
        mark(5);
        space(350);
        chk("glitch_alone", done_cnt, exp_done);
        mark(100); space(50); mark(5); space(50); mark(100); space(50); mark(100);
        expect_char("glitch_mid", 2'b01, 4'b0000, 3'd3, 1'b0);

        // 249 ms is a dot, 250 ms a dash
        send(2, '{249, 250, 0, 0, 0});
        expect_char("thresh", 2'b11, 4'b0010, 3'd2, 1'b0);

        // Fifth symbol overflows and is not recorded
        send(5, '{100, 100, 100, 100, 400});
        expect_char("ovf", 2'b11, 4'b0000, 3'd4, 1'b0);

        // Abort mid-mark after an S; history must be cleared so O,S gives no sos
        send(3, '{100, 100, 100, 0, 0});
        expect_char("pre_abort", 2'b01, 4'b0000, 3'd3, 1'b0);
        mark(100);
        space(50);
        pin_in = 1'b0;
        cyc(50 * CPM);
        start_sig = 1'b0;
        cyc(10);
        chk("abort_hold_code", char_code, 2'b01);
        cyc(50 * CPM);
        pin_in = 1'b1;
        cyc(10);
        start_sig = 1'b1;
        space(350);
        chk("abort_nodone", done_cnt, exp_done);
        send(3, '{400, 400, 400, 0, 0});
        expect_char("abort_o", 2'b10, 4'b0111, 3'd3, 1'b0);
        send(3, '{100, 100, 100, 0, 0});
        expect_char("abort_s", 2'b01, 4'b0000, 3'd3, 1'b0);

        // Async reset in the middle of a gap
        mark(100); space(50); mark(100);
        space(100);
        RSTn = 1'b0;
        cyc(3);
        chk_reset_outs("rst_gap");
        RSTn = 1'b1;
        space(400);
        chk("rst_gap_nodone", done_cnt, exp_done);
        chk("rst_gap_code", char_code, 2'b00);

        chk("sos_total", sos_cnt, 1);
        chk("pulse_shape", bad_pulse, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
